muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage. Handles signed and unsigned operation.
//  Shift-add multiply and restoring divide, one result bit per cycle.
//  Drives a stall request so EX holds the instruction until the result is ready.
//  Returns a {hi,lo} result for the HI/LO write path in MEM/WB.
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  start_i      in   1        request; sampled only in IDLE
//  op_i         in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  opdata1_i    in   WIDTH    multiplicand / dividend
//  opdata2_i    in   WIDTH    multiplier / divisor
//  annul_i      in   1        abort current operation (pipeline flush)
//  result_o     out  2*WIDTH  mul: product {hi,lo}; div: {remainder,quotient}
//  ready_o      out  1        1-cycle pulse: result_o newly valid
//  busy_o       out  1        operation in flight (state != IDLE)
//  stallreq_o   out  1        stall request to the stall controller
//  divzero_o    out  1        divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE. result_o, ready_o, busy_o, stallreq_o, divzero_o, counter and all datapath registers = 0.
//    A reset during CALC/DONE aborts the operation immediately.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE:
//    - start_i & !annul_i: latch |opdata1|, |opdata2| (abs only for signed ops) and sign bits; counter = 0; go to CALC.
//    - start_i & annul_i: annul wins; stay in IDLE.
//  - CALC: one iteration per cycle; counter increments.
//    - When counter == WIDTH-1, go to DONE and register the sign-corrected result into result_o.
//  - DONE:
//    - ready_o = 1 and result_o is valid in this cycle; ready_o is 0 in every other state.
//    - Next state is IDLE.
//    - start_i is ignored in DONE; it is accepted again from IDLE.
//  - Latency: start accepted at edge T -> ready_o high in cycle T+WIDTH+1.
//  - stallreq_o (combinational) = (IDLE & start_i & !annul_i) | CALC. It is low in DONE, so EX advances on the ready cycle.
//  - start_i in CALC is ignored. Operands are latched, so input changes after acceptance have no effect.
//  - annul_i in CALC or DONE:
//    - next state IDLE; ready_o stays 0 (including a DONE-cycle annul).
//    - result_o holds its previous value.
//  - result_o holds its last value until the next completion.
//  - Signed fix-up:
//    - product negated iff s1^s2;
//    - quotient negated iff s1^s2;
//    - remainder takes the sign of the dividend.
//    - Most-negative operand magnitude is 2^(WIDTH-1), computed unsigned.
//    - DIV of the most-negative value by -1 wraps: quotient = most-negative value, remainder = 0.
//  - Divide by zero (macro absent): runs the full WIDTH iterations, giving unsigned quotient = all ones and remainder = dividend.
//    For DIV the signed fix-up is then applied as normal. divzero_o stays 0.
// CONFIGURATION
//  - MULDIV_DIVZERO_EN defined:
//    - DIVU/DIV with opdata2_i == 0 skips CALC: IDLE -> DONE, so ready_o is high in cycle T+1.
//    - result_o = 0 and divzero_o = 1 during that DONE cycle only.
//    - stallreq_o is high for the acceptance cycle only.
//  - MULDIV_DIVZERO_EN undefined:
//    - divzero_o is tied to 0.
//    - Divide by zero uses the full-latency path described above.
// TESTING  (WIDTH=32)
//  1. DIVU 100/7 -> result_o = {32'd2, 32'd14}. ready_o is a 1-cycle pulse at T+33. stallreq_o is high from T to T+32.
//  2. DIV -7/2 -> {32'hFFFFFFFF, 32'hFFFFFFFD}. DIV 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}.
//  3. MULT 0xFFFFFFFF*5 -> 64'hFFFFFFFF_FFFFFFFB. MULTU with the same operands -> 64'h00000004_FFFFFFFB.
//  4. annul_i on CALC iteration 10 -> next cycle IDLE and ready_o never pulses; result_o is unchanged.
//     A MULTU 3*4 issued the following cycle returns 64'd12 at +33.
//  5. DIVU 123/0:
//     - macro off: {32'd123, 32'hFFFFFFFF} at T+33, divzero_o = 0.
//     - macro on: result_o = 0 with ready_o = divzero_o = 1 at T+1.
//  6. rst asserted mid-CALC -> next cycle all outputs 0 and busy_o = 0. start_i and annul_i asserted together in IDLE -> no acceptance.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider for the EX stage.
// Ports: clk, rst (sync, active-high); start_i, op_i, opdata1_i, opdata2_i,
//   annul_i in; result_o {hi,lo}, ready_o, busy_o, stallreq_o, divzero_o out.
// Optional build macro MULDIV_DIVZERO_EN: a zero divisor finishes in one
//   cycle with result 0 and divzero_o set; otherwise divzero_o is tied low.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stallreq_o,
    output logic               divzero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] pend;
    logic [2*WIDTH-1:0] res_q;

    // Operand magnitudes and sign bits at acceptance
    logic               sgn;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic               accept;

    assign sgn    = op_i[0];
    assign s1     = sgn & opdata1_i[WIDTH-1];
    assign s2     = sgn & opdata2_i[WIDTH-1];
    assign abs1   = s1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs2   = s2 ? (~opdata2_i + 1'b1) : opdata2_i;
    assign accept = (state == S_IDLE) & start_i & ~annul_i;

    // One iteration of either datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_df;
    logic [WIDTH-1:0]   div_hi;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;

    always_comb begin
        mul_sum = {1'b0, hi_q};
        if (lo_q[0]) begin
            mul_sum = {1'b0, hi_q} + {1'b0, a_q};
        end
        mul_hi = mul_sum[WIDTH:1];
        mul_lo = {mul_sum[0], lo_q[WIDTH-1:1]};

        // Remainder stays below the divisor, so W bits of the
        // difference are enough; a zero divisor always "fits".
        div_sh = {hi_q, lo_q[WIDTH-1]};
        div_ge = (div_sh >= {1'b0, b_q});
        div_df = div_sh[WIDTH-1:0] - b_q;
        div_hi = div_ge ? div_df : div_sh[WIDTH-1:0];
        div_lo = {lo_q[WIDTH-2:0], div_ge};

        hi_n = is_div ? div_hi : mul_hi;
        lo_n = is_div ? div_lo : mul_lo;
    end

    // Sign fix-up of the final iteration's output
    logic [2*WIDTH-1:0] prod_n;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] fin;

    always_comb begin
        prod_n  = {hi_n, lo_n};
        mul_res = neg_res ? (~prod_n + 1'b1) : prod_n;
        quo_fix = neg_res ? (~lo_n + 1'b1) : lo_n;
        rem_fix = neg_rem ? (~hi_n + 1'b1) : hi_n;
        fin     = is_div ? {rem_fix, quo_fix} : mul_res;
    end

`ifdef MULDIV_DIVZERO_EN
    logic dz_q;
    logic dz_hit;
    assign dz_hit = op_i[1] & (opdata2_i == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            pend    <= '0;
            res_q   <= '0;
`ifdef MULDIV_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= abs1;
                        b_q     <= abs2;
                        hi_q    <= '0;
                        lo_q    <= op_i[1] ? abs1 : abs2;
                        is_div  <= op_i[1];
                        neg_res <= s1 ^ s2;
                        neg_rem <= s1;
                        cnt     <= '0;
`ifdef MULDIV_DIVZERO_EN
                        if (dz_hit) begin
                            state <= S_DONE;
                            pend  <= '0;
                            dz_q  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            dz_q  <= 1'b0;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_DONE;
                            pend  <= fin;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    // An annulled completion leaves the old result visible
                    if (!annul_i) begin
                        res_q <= pend;
                    end
`ifdef MULDIV_DIVZERO_EN
                    dz_q <= 1'b0;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // New result is shown directly from pend in the ready cycle;
    // res_q keeps it afterwards until the next completion.
    assign ready_o    = (state == S_DONE) & ~annul_i;
    assign result_o   = ready_o ? pend : res_q;
    assign busy_o     = (state != S_IDLE);
    assign stallreq_o = accept | (state == S_CALC);

`ifdef MULDIV_DIVZERO_EN
    assign divzero_o = ready_o & dz_q;
`else
    assign divzero_o = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed corner cases plus
// random operations compared against an arithmetic reference model.
module tb_muldiv_iter;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [1:0]    op_i;
    logic [W-1:0]  opdata1_i;
    logic [W-1:0]  opdata2_i;
    logic          annul_i;
    logic [2*W-1:0] result_o;
    logic          ready_o;
    logic          busy_o;
    logic          stallreq_o;
    logic          divzero_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_exp = '0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o),
        .divzero_o  (divzero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return ua * ub;
            2'b01: return sa * sb;
            2'b10: begin
`ifdef MULDIV_DIVZERO_EN
                if (b == 0) return 64'd0;
`else
                if (b == 0) return {a, 32'hFFFFFFFF};
`endif
                return {a % b, a / b};
            end
            default: begin
`ifdef MULDIV_DIVZERO_EN
                if (b == 0) return 64'd0;
`else
                // All-ones quotient negated when the dividend is negative
                if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
`endif
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        int lat;
        bit dz;
        bit stall_ok;
        dz  = op[1] && (b == 0);
        exp = model(op, a, b);
        lat = W + 1;
`ifdef MULDIV_DIVZERO_EN
        if (dz) lat = 1;
`endif
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        @(negedge clk);
        chk({tag, ":stall_acc"}, 64'(stallreq_o), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        opdata1_i = $urandom; opdata2_i = $urandom;
        op_i = 2'($urandom);
        n = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!ready_o) begin
                if (!stallreq_o || !busy_o) stall_ok = 1'b0;
                start_i = 1'($urandom);
            end
        end while (!ready_o && n < 100);
        start_i = 1'b0;
        chk({tag, ":latency"}, 64'(n), 64'(lat));
        chk({tag, ":result"}, result_o, exp);
`ifdef MULDIV_DIVZERO_EN
        chk({tag, ":divzero"}, 64'(divzero_o), 64'(dz));
`else
        chk({tag, ":divzero"}, 64'(divzero_o), 64'd0);
`endif
        chk({tag, ":stall_calc"}, 64'(stall_ok), 64'd1);
        chk({tag, ":stall_done"}, 64'(stallreq_o), 64'd0);
        @(negedge clk);
        chk({tag, ":pulse"}, 64'(ready_o), 64'd0);
        chk({tag, ":hold"}, result_o, exp);
        chk({tag, ":idle"}, 64'(busy_o), 64'd0);
        last_exp = exp;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit pulsed;

        rst = 1'b1; start_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_stall", 64'(stallreq_o), 64'd0);
        chk("rst_dz", 64'(divzero_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        chk("divu_100_7_const", last_exp, {32'd2, 32'd14});
        run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2);
        run_op("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF);
        run_op("mult_m1_5", 2'b01, 32'hFFFFFFFF, 32'd5);
        run_op("multu_m1_5", 2'b00, 32'hFFFFFFFF, 32'd5);
        run_op("mult_minneg", 2'b01, 32'h80000000, 32'h80000000);
        run_op("divu_123_0", 2'b10, 32'd123, 32'd0);
        run_op("div_m9_0", 2'b11, 32'hFFFFFFF7, 32'd0);

        // Annul on CALC iteration 10
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b00;
        opdata1_i = 32'd1234; opdata2_i = 32'd5678;
        @(posedge clk); #1;
        start_i = 1'b0;
        pulsed = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ready_o) pulsed = 1'b1;
            @(posedge clk);
        end
        #1 annul_i = 1'b1;
        @(negedge clk);
        if (ready_o) pulsed = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        if (ready_o) pulsed = 1'b1;
        chk("annul_idle", 64'(busy_o), 64'd0);
        chk("annul_nopulse", 64'(pulsed), 64'd0);
        chk("annul_result", result_o, last_exp);
        run_op("multu_3_4", 2'b00, 32'd3, 32'd4);

        // Simultaneous start and annul in IDLE
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01;
        @(negedge clk);
        chk("sa_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        chk("sa_busy", 64'(busy_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // Reset mid-CALC
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b11;
        opdata1_i = 32'd999; opdata2_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_result", result_o, 64'd0);
        chk("mrst_ready", 64'(ready_o), 64'd0);
        chk("mrst_busy", 64'(busy_o), 64'd0);
        chk("mrst_stall", 64'(stallreq_o), 64'd0);
        chk("mrst_dz", 64'(divzero_o), 64'd0);
        run_op("post_rst", 2'b10, 32'd100, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
